// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one slave bus between the instruction-fetch (imem) and
// data (dmem) masters. One transaction at a time: IDLE -> arbitrate + decode,
// BUSY -> drive the selected slave until ready or timeout, RESP -> one-cycle
// ready pulse to the granted master. Every output comes straight from a flop.
//
// Ports:
//   clock, reset            system clock, asynchronous active-high reset
//   imem_*                  fetch master: valid/addr in, ready/rdata/error out
//   dmem_*                  data master: valid/addr/wdata/wstrb in, ready/rdata/error out
//   slave_addr/wdata/wstrb  latched request, shared by all slaves
//   slave_instr             1 while serving a fetch
//   <slave>_valid/ready/rdata  per-slave handshake for bram, print, clint, clic
module bus_arbiter #(
  parameter logic [31:0] bram_base_addr  = 32'h0000000,
  parameter logic [31:0] bram_top_addr   = 32'h0100000,
  parameter logic [31:0] print_base_addr = 32'h1000000,
  parameter logic [31:0] print_top_addr  = 32'h1000004,
  parameter logic [31:0] clint_base_addr = 32'h2000000,
  parameter logic [31:0] clint_top_addr  = 32'h200C000,
  parameter logic [31:0] clic_base_addr  = 32'h3000000,
  parameter logic [31:0] clic_top_addr   = 32'h3005000,
  parameter logic [15:0] timeout_cycles  = 16'd1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic        imem_ready,
  output logic [31:0] imem_rdata,
  output logic        imem_error,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,
  output logic        dmem_error,
  output logic [31:0] slave_addr,
  output logic [31:0] slave_wdata,
  output logic [3:0]  slave_wstrb,
  output logic        slave_instr,
  output logic        bram_valid,
  output logic        print_valid,
  output logic        clint_valid,
  output logic        clic_valid,
  input  logic        bram_ready,
  input  logic        print_ready,
  input  logic        clint_ready,
  input  logic        clic_ready,
  input  logic [31:0] bram_rdata,
  input  logic [31:0] print_rdata,
  input  logic [31:0] clint_rdata,
  input  logic [31:0] clic_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_instr_q, last_instr_d;  // 1 = last grant went to fetch
  logic        instr_q, instr_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [3:0]  sel_q, sel_d;                // {clic, clint, print, bram}
  logic [15:0] cnt_q, cnt_d;
  logic        irdy_q, irdy_d, ierr_q, ierr_d, drdy_q, drdy_d, derr_q, derr_d;

  logic        pick_data;
  logic [31:0] req_addr;
  logic [3:0]  hit, hit_1h, slv_rdy;
  logic        sel_rdy;
  logic [31:0] sel_rdata;

  // Tie goes to whichever master did not win last time.
  assign pick_data = dmem_valid & (~imem_valid | last_instr_q);
  assign req_addr  = pick_data ? dmem_addr : imem_addr;

  assign hit[0] = (req_addr >= bram_base_addr)  && (req_addr < bram_top_addr);
  assign hit[1] = (req_addr >= print_base_addr) && (req_addr < print_top_addr);
  assign hit[2] = (req_addr >= clint_base_addr) && (req_addr < clint_top_addr);
  assign hit[3] = (req_addr >= clic_base_addr)  && (req_addr < clic_top_addr);
  // Regions should not overlap; if misconfigured, lowest index wins so the
  // select stays one-hot.
  assign hit_1h = hit[0] ? 4'b0001 : hit[1] ? 4'b0010 :
                  hit[2] ? 4'b0100 : hit[3] ? 4'b1000 : 4'b0000;

  assign slv_rdy   = {clic_ready, clint_ready, print_ready, bram_ready};
  assign sel_rdy   = |(sel_q & slv_rdy);
  assign sel_rdata = ({32{sel_q[0]}} & bram_rdata)  | ({32{sel_q[1]}} & print_rdata) |
                     ({32{sel_q[2]}} & clint_rdata) | ({32{sel_q[3]}} & clic_rdata);

  always_comb begin
    state_d      = state_q;
    last_instr_d = last_instr_q;
    instr_d      = instr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    irdy_d       = 1'b0;
    ierr_d       = 1'b0;
    drdy_d       = 1'b0;
    derr_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (imem_valid || dmem_valid) begin
          instr_d      = ~pick_data;
          last_instr_d = ~pick_data;
          addr_d       = req_addr;
          wdata_d      = pick_data ? dmem_wdata : 32'h0;
          wstrb_d      = pick_data ? dmem_wstrb : 4'h0;
          cnt_d        = 16'd0;
          if (|hit) begin
            sel_d   = hit_1h;
            state_d = BUSY;
          end else begin
            // Unmapped: answer with an error straight away, nothing driven.
            rdata_d = 32'h0;
            irdy_d  = ~pick_data;
            ierr_d  = ~pick_data;
            drdy_d  = pick_data;
            derr_d  = pick_data;
            state_d = RESP;
          end
        end
      end
      BUSY: begin
        if (sel_rdy) begin
          rdata_d = sel_rdata;
          sel_d   = 4'b0000;
          irdy_d  = instr_q;
          drdy_d  = ~instr_q;
          state_d = RESP;
        end else if ({1'b0, cnt_q} + 17'd1 >= {1'b0, timeout_cycles}) begin
          // timeout_cycles BUSY cycles have elapsed with no ready.
          rdata_d = 32'h0;
          sel_d   = 4'b0000;
          irdy_d  = instr_q;
          ierr_d  = instr_q;
          drdy_d  = ~instr_q;
          derr_d  = ~instr_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_instr_q <= 1'b1;
      instr_q      <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      wstrb_q      <= 4'h0;
      sel_q        <= 4'b0000;
      cnt_q        <= 16'd0;
      rdata_q      <= 32'h0;
      irdy_q       <= 1'b0;
      ierr_q       <= 1'b0;
      drdy_q       <= 1'b0;
      derr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_instr_q <= last_instr_d;
      instr_q      <= instr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      irdy_q       <= irdy_d;
      ierr_q       <= ierr_d;
      drdy_q       <= drdy_d;
      derr_q       <= derr_d;
    end
  end

  assign imem_ready  = irdy_q;
  assign imem_error  = ierr_q;
  assign imem_rdata  = rdata_q;
  assign dmem_ready  = drdy_q;
  assign dmem_error  = derr_q;
  assign dmem_rdata  = rdata_q;
  assign slave_addr  = addr_q;
  assign slave_wdata = wdata_q;
  assign slave_wstrb = wstrb_q;
  assign slave_instr = instr_q;
  assign bram_valid  = sel_q[0];
  assign print_valid = sel_q[1];
  assign clint_valid = sel_q[2];
  assign clic_valid  = sel_q[3];

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_valid = 1'b0, dmem_valid = 1'b0;
  logic [31:0] imem_addr = 32'h0, dmem_addr = 32'h0, dmem_wdata = 32'h0;
  logic [3:0]  dmem_wstrb = 4'h0;
  logic        imem_ready, imem_error, dmem_ready, dmem_error;
  logic [31:0] imem_rdata, dmem_rdata, slave_addr, slave_wdata;
  logic [3:0]  slave_wstrb;
  logic        slave_instr, bram_valid, print_valid, clint_valid, clic_valid;

  // slave models: index 0 bram, 1 print, 2 clint, 3 clic
  logic [3:0]  rdy = 4'h0;
  logic [31:0] dat [4];
  int          lat [4];
  bit          en  [4];
  int          scnt[4];
  int          vcnt[4];
  bit          noise = 1'b0;   // non-selected slaves assert ready
  wire  [3:0]  sv = {clic_valid, clint_valid, print_valid, bram_valid};

  int cyc = 0;
  int total = 0, bad = 0;

  typedef struct {bit instr; logic [31:0] rdata; bit err; int cyc;} exp_t;
  exp_t sb[$];

  bus_arbiter #(.timeout_cycles(16'd8)) dut (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .imem_error(imem_error),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dmem_error(dmem_error),
    .slave_addr(slave_addr), .slave_wdata(slave_wdata), .slave_wstrb(slave_wstrb),
    .slave_instr(slave_instr),
    .bram_valid(bram_valid), .print_valid(print_valid),
    .clint_valid(clint_valid), .clic_valid(clic_valid),
    .bram_ready(rdy[0]), .print_ready(rdy[1]), .clint_ready(rdy[2]), .clic_ready(rdy[3]),
    .bram_rdata(dat[0]), .print_rdata(dat[1]), .clint_rdata(dat[2]), .clic_rdata(dat[3])
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Slave responders: ready lat[s] cycles after valid rises (if enabled).
  always @(negedge clock) begin
    for (int s = 0; s < 4; s++) begin
      if (sv[s]) begin
        rdy[s] = en[s] && (scnt[s] == lat[s]);
        scnt[s]++;
        vcnt[s]++;
      end else begin
        rdy[s]  = noise;
        scnt[s] = 0;
      end
    end
  end

  // Response monitor: pops the scoreboard on every ready pulse.
  always @(negedge clock) begin
    exp_t e;
    chk("valid_onehot", 64'($countones(sv) <= 1), 64'd1);
    if (imem_ready || dmem_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", {62'd0, imem_ready, dmem_ready}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_master", 64'(imem_ready), 64'(e.instr));
        chk("rsp_both", 64'(imem_ready && dmem_ready), 64'd0);
        chk("rsp_rdata", 64'(imem_ready ? imem_rdata : dmem_rdata), 64'(e.rdata));
        chk("rsp_error", 64'(imem_ready ? imem_error : dmem_error), 64'(e.err));
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Drive a request at the next negedge; dly = cycles until its ready pulse.
  task automatic issue(input bit instr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [31:0] erd, input bit eer,
                       input int dly);
    exp_t e;
    @(negedge clock);
    if (instr) begin
      imem_valid = 1'b1; imem_addr = a;
    end else begin
      dmem_valid = 1'b1; dmem_addr = a; dmem_wdata = wd; dmem_wstrb = ws;
    end
    e.instr = instr; e.rdata = erd; e.err = eer; e.cyc = cyc + dly;
    sb.push_back(e);
  endtask

  task automatic wait_ready(input bit instr);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(instr ? imem_ready : dmem_ready) && n < 100);
    chk(instr ? "imem_wait" : "dmem_wait", 64'(n < 100), 64'd1);
    if (instr) imem_valid = 1'b0; else dmem_valid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {54'd0, imem_ready, imem_error, dmem_ready, dmem_error,
                        sv, slave_instr, slave_wstrb == 4'h0}, 64'd1);
    chk({tag, "_rdata"}, {imem_rdata, dmem_rdata}, 64'd0);
    chk({tag, "_slave"}, {slave_addr, slave_wdata}, 64'd0);
  endtask

  typedef struct {logic [31:0] a; int s; bit err;} bnd_t;
  bnd_t bnd[4];

  initial begin
    int base[4];
    for (int s = 0; s < 4; s++) begin
      dat[s] = 32'h1000_0000 * (s + 1) + 32'h1; lat[s] = 0; en[s] = 1'b1;
      scnt[s] = 0; vcnt[s] = 0;
    end
    repeat (3) @(negedge clock);
    chk_zero("reset");
    reset = 1'b0;

    // Tie from reset: data wins, then fetch with slave_instr=1, wstrb=0.
    @(negedge clock);
    imem_valid = 1'b1; imem_addr = 32'h100;
    dmem_valid = 1'b1; dmem_addr = 32'h100; dmem_wdata = 32'h55; dmem_wstrb = 4'h3;
    sb.push_back('{1'b0, dat[0], 1'b0, cyc + 2});
    sb.push_back('{1'b1, dat[0], 1'b0, cyc + 5});
    @(negedge clock);
    chk("tie1_data_first", {bram_valid, slave_instr, slave_wstrb}, {58'd0, 1'b1, 1'b0, 4'h3});
    @(negedge clock);
    dmem_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("tie1_fetch", {bram_valid, slave_instr, slave_wstrb}, {58'd0, 1'b1, 1'b1, 4'h0});
    @(negedge clock);
    chk("tie1_fetch_rdy", 64'(imem_ready), 64'd1);
    imem_valid = 1'b0;

    // Data read, BRAM ready 2 cycles after valid.
    lat[0] = 2; dat[0] = 32'hDEADBEEF;
    for (int s = 0; s < 4; s++) base[s] = vcnt[s];
    issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 4);
    wait_ready(1'b0);
    chk("read_bram_cycles", 64'(vcnt[0] - base[0]), 64'd3);
    chk("read_others_idle", 64'((vcnt[1] - base[1]) + (vcnt[2] - base[2]) + (vcnt[3] - base[3])), 64'd0);

    // Last grant was data, so this tie goes to fetch first.
    lat[0] = 0;
    @(negedge clock);
    imem_valid = 1'b1; imem_addr = 32'h100;
    dmem_valid = 1'b1; dmem_addr = 32'h104; dmem_wstrb = 4'h0;
    sb.push_back('{1'b1, dat[0], 1'b0, cyc + 2});
    sb.push_back('{1'b0, dat[0], 1'b0, cyc + 5});
    wait_ready(1'b1);
    wait_ready(1'b0);

    // Print write, then its exclusive top boundary.
    dat[1] = 32'h7;
    base[1] = vcnt[1];
    issue(1'b0, 32'h1000000, 32'h41, 4'hF, 32'h7, 1'b0, 2);
    @(negedge clock);
    chk("print_req", {print_valid, slave_wstrb, slave_wdata, slave_addr[26:0]},
        {1'b1, 4'hF, 32'h41, 27'h1000000});
    wait_ready(1'b0);
    base[1] = vcnt[1];
    issue(1'b0, 32'h1000004, 32'h42, 4'hF, 32'h0, 1'b1, 1);
    wait_ready(1'b0);
    chk("print_top_untouched", 64'(vcnt[1] - base[1]), 64'd0);

    // Region boundaries.
    bnd[0] = '{32'h00FFFFC, 0, 1'b0};
    bnd[1] = '{32'h0100000, 0, 1'b1};
    bnd[2] = '{32'h200BFFC, 2, 1'b0};
    bnd[3] = '{32'h3005000, 3, 1'b1};
    lat[0] = 1;
    for (int i = 0; i < 4; i++) begin
      base[bnd[i].s] = vcnt[bnd[i].s];
      issue(1'b0, bnd[i].a, 32'h0, 4'h0, bnd[i].err ? 32'h0 : dat[bnd[i].s], bnd[i].err,
            bnd[i].err ? 1 : 2 + lat[bnd[i].s]);
      wait_ready(1'b0);
      chk($sformatf("bnd%0d_slave_cycles", i), 64'(vcnt[bnd[i].s] - base[bnd[i].s]),
          bnd[i].err ? 64'd0 : 64'(lat[bnd[i].s] + 1));
    end

    // Timeout: CLIC silent, other slaves spraying ready.
    en[3] = 1'b0; noise = 1'b1;
    base[3] = vcnt[3];
    issue(1'b0, 32'h3000000, 32'h0, 4'h0, 32'h0, 1'b1, 9);
    wait_ready(1'b0);
    chk("timeout_clic_cycles", 64'(vcnt[3] - base[3]), 64'd8);
    noise = 1'b0;

    // Reset mid-BUSY: everything drops without waiting for a clock edge.
    issue(1'b0, 32'h3000010, 32'h9, 4'h1, 32'h0, 1'b1, 9);
    repeat (3) @(negedge clock);
    chk("pre_reset_busy", 64'(clic_valid), 64'd1);
    #2 reset = 1'b1;
    #1 chk_zero("async_reset");
    sb.delete();
    dmem_valid = 1'b0;
    en[3] = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    issue(1'b1, 32'h200, 32'h0, 4'h0, dat[0], 1'b0, 3);
    wait_ready(1'b1);
    lat[0] = 0;
    @(negedge clock);
    imem_valid = 1'b1; imem_addr = 32'h100;
    dmem_valid = 1'b1; dmem_addr = 32'h100; dmem_wstrb = 4'h0;
    sb.push_back('{1'b0, dat[0], 1'b0, cyc + 2});
    sb.push_back('{1'b1, dat[0], 1'b0, cyc + 5});
    wait_ready(1'b0);
    wait_ready(1'b1);

    repeat (2) @(negedge clock);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
